sram_burst_reader: RTL and testbench
====================================

Name: sram_burst_reader

Overview:
Read-side sequencer for the 256x32 one-write/one-read SRAM macro. It consumes a burst request (start address, word count) and drives the macro's read port (chip select, address) one word per cycle. It captures each returned word at its fixed one-cycle latency and presents the data as a valid/ready stream to the downstream datapath. Backpressure is absorbed by a small credit-controlled output buffer, because the macro's read data holds only until the next clock edge and cannot be stalled.

Parameters:
DATA_WIDTH, 32, SRAM word width
ADDR_WIDTH, 8, SRAM address width (depth 1<<ADDR_WIDTH)
LEN_WIDTH, 9, burst length field width (max burst 256 words)
BUF_DEPTH, 2, output buffer entries (power of two, >=2)

Ports:
clk  in  1  single clock, shared with the SRAM read port (clk1)
rst  in  1  synchronous, active-high reset
req_valid  in  1  burst request valid
req_ready  out  1  high only in IDLE
req_addr  in  ADDR_WIDTH  start word address
req_len  in  LEN_WIDTH  words to read; 0 allowed
sram_csb  out  1  to SRAM csb1, active low, combinational
sram_addr  out  ADDR_WIDTH  to SRAM addr1, combinational
sram_dout  in  DATA_WIDTH  from SRAM dout1
out_valid  out  1  stream data valid
out_ready  in  1  downstream accept
out_data  out  DATA_WIDTH  stream word
out_last  out  1  marks final word of burst
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse at burst completion

Behaviour:
- Clock and reset: single clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: state=IDLE, req_ready=1, sram_csb=1, sram_addr=0, out_valid=0, out_last=0, busy=0, done=0. Buffer count, pending flag and remaining counter are all 0.
- States: IDLE, ISSUE, DRAIN.
- IDLE:
  - req_valid&&req_ready latches cur_addr=req_addr and remaining=req_len.
  - If req_len!=0, go to ISSUE. If req_len==0, stay IDLE and pulse done on the next cycle; no SRAM access.
- Issue condition, evaluated combinationally in ISSUE: remaining!=0 && (count + pending - pop) < BUF_DEPTH.
  - pop = out_valid&&out_ready.
  - When the condition holds: sram_csb=0 and sram_addr=cur_addr. Otherwise sram_csb=1 and sram_addr holds its last value.
- On each issue edge:
  - pending<=1, cur_addr<=cur_addr+1, wrapping mod 2^ADDR_WIDTH (0xFF->0x00).
  - remaining<=remaining-1.
  - The issued word is tagged last if remaining==1.
- Capture: when pending==1, sram_dout is written into the buffer at the very next edge, unconditionally; the credit check guarantees space. pending clears unless a new issue occurs in the same cycle.
- Read latency: request cycle N, word present at out_data in cycle N+1. Back-to-back issue with out_ready=1 gives one word per cycle.
- Transitions:
  - ISSUE->DRAIN when the last word is issued.
  - DRAIN->IDLE on the edge where the last-tagged word pops; done pulses in the following cycle.
- Output buffer is a FIFO: out_data/out_last come from the head entry. Simultaneous push and pop in one cycle leaves count unchanged.
- out_valid may not drop without a handshake; out_data is stable while out_valid&&!out_ready.
- rst mid-burst: on the reset edge everything returns to reset values, buffered and in-flight words are discarded, and sram_csb=1 from the next cycle.
- A new request is never accepted before done of the previous burst.

Optional Feature:
SRAM_RD_COLLISION_CHK_EN:
- Defined: adds inputs wr_csb (1) and wr_addr (ADDR_WIDTH), mirroring the SRAM write port, and output err_collision (1).
- err_collision sets sticky when sram_csb==0 && wr_csb==0 && sram_addr==wr_addr in the same cycle. It is cleared only by rst.
- Read data is still delivered unchanged.
- Undefined: these ports and the logic do not exist.

Test Plan:
- Burst addr=0x10, len=4, out_ready=1, SRAM preloaded mem[i]=i*3 -> out_data 0x30,0x33,0x36,0x39 in 4 consecutive cycles starting one cycle after the first csb low; out_last on 0x39; done one cycle after the last pop.
- Wrap: addr=0xFE, len=4 -> sram_addr sequence 0xFE,0xFF,0x00,0x01; data matches those locations.
- Backpressure: len=8, out_ready toggling 1,0,0,1,... -> no word lost or duplicated; sram_csb never low when count+pending-pop>=2; out_data stable while stalled.
- len=0 -> no sram_csb low; done pulses once; req_ready high again the next cycle.
- Reset asserted on the 3rd issue cycle of len=16 -> next cycle: out_valid=0, sram_csb=1, busy=0. A fresh len=2 burst then returns the correct 2 words.
- With SRAM_RD_COLLISION_CHK_EN: wr_csb=0, wr_addr=0x12 during the issue of addr 0x12 -> err_collision=1 and stays set until rst.

Source files
------------

// File: rtl/sram_burst_reader.sv
// sram_burst_reader: burst read sequencer for a 1-cycle-latency SRAM read port, with a credit-controlled fall-through output FIFO.
// Ports: clk/rst (sync, active-high); req_valid/req_ready/req_addr/req_len burst request;
// sram_csb/sram_addr/sram_dout SRAM read port; out_valid/out_ready/out_data/out_last stream;
// busy (state != IDLE), done (one-cycle pulse at burst completion).
// Optional: define SRAM_RD_COLLISION_CHK_EN to add wr_csb/wr_addr inputs and the sticky err_collision output.
module sram_burst_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 9,
  parameter int BUF_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LEN_WIDTH-1:0]  req_len,
  output logic                  sram_csb,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  input  logic [DATA_WIDTH-1:0] sram_dout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
`ifdef SRAM_RD_COLLISION_CHK_EN
  ,input  logic                  wr_csb
  ,input  logic [ADDR_WIDTH-1:0] wr_addr
  ,output logic                  err_collision
`endif
);
  localparam int PW = $clog2(BUF_DEPTH);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  state_t state;
  logic [ADDR_WIDTH-1:0] cur_addr, addr_hold;
  logic [LEN_WIDTH-1:0] remaining;
  logic pending, pend_last;
  logic [DATA_WIDTH-1:0] buf_data [BUF_DEPTH];
  logic [BUF_DEPTH-1:0] buf_last;
  logic [PW-1:0] head, tail;
  logic [PW:0] count;
  logic [PW+1:0] occ;
  logic empty, pop, pop_buf, push, issue;
  assign empty = count == '0;
  // Fall-through: with an empty buffer the word arriving from the SRAM is presented directly.
  assign out_valid = !empty || pending;
  assign out_data = empty ? sram_dout : buf_data[head];
  assign out_last = out_valid && (empty ? pend_last : buf_last[head]);
  assign pop = out_valid && out_ready;
  assign pop_buf = pop && !empty;
  assign push = pending && !(pop && empty);
  // Occupancy after this edge; an issue reserves one more slot for the word it produces.
  assign occ = {1'b0, count} + (PW+2)'(pending) - (PW+2)'(pop);
  assign issue = state == ISSUE && remaining != '0 && occ < (PW+2)'(BUF_DEPTH);
  assign sram_csb = !issue;
  assign sram_addr = issue ? cur_addr : addr_hold;
  assign req_ready = state == IDLE;
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cur_addr <= '0;
      addr_hold <= '0;
      remaining <= '0;
      pending <= 1'b0;
      pend_last <= 1'b0;
      head <= '0;
      tail <= '0;
      count <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      pending <= issue;
      if (issue) begin
        cur_addr <= cur_addr + 1'b1;
        addr_hold <= cur_addr;
        remaining <= remaining - 1'b1;
        pend_last <= remaining == LEN_WIDTH'(1);
      end
      if (push) begin
        buf_data[tail] <= sram_dout;
        buf_last[tail] <= pend_last;
        tail <= tail + 1'b1;
      end
      if (pop_buf) head <= head + 1'b1;
      count <= count + (PW+1)'(push) - (PW+1)'(pop_buf);
      case (state)
        IDLE: if (req_valid) begin
          cur_addr <= req_addr;
          remaining <= req_len;
          if (req_len != '0) state <= ISSUE;
          else done <= 1'b1;
        end
        ISSUE: if (issue && remaining == LEN_WIDTH'(1)) state <= DRAIN;
        DRAIN: if (pop && out_last) begin
          state <= IDLE;
          done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef SRAM_RD_COLLISION_CHK_EN
  always_ff @(posedge clk) begin
    if (rst) err_collision <= 1'b0;
    else if (!sram_csb && !wr_csb && sram_addr == wr_addr) err_collision <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_sram_burst_reader.sv
// tb_sram_burst_reader: randomized self-checking bench for sram_burst_reader against a queue-based burst model.
module tb_sram_burst_reader;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_ready;
  logic [7:0] req_addr = 0;
  logic [8:0] req_len = 0;
  logic sram_csb;
  logic [7:0] sram_addr;
  logic [31:0] sram_dout = 0;
  logic out_valid, out_ready = 1, out_last, busy, done;
  logic [31:0] out_data;
`ifdef SRAM_RD_COLLISION_CHK_EN
  logic wr_csb = 1, err_collision;
  logic [7:0] wr_addr = 0;
`endif
  sram_burst_reader dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_len(req_len), .sram_csb(sram_csb), .sram_addr(sram_addr),
    .sram_dout(sram_dout), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .busy(busy), .done(done)
`ifdef SRAM_RD_COLLISION_CHK_EN
    , .wr_csb(wr_csb), .wr_addr(wr_addr), .err_collision(err_collision)
`endif
  );
  always #5 clk = ~clk;
  logic [31:0] mem [256];
  always @(posedge clk) if (!sram_csb) sram_dout <= mem[sram_addr];
  int n_chk = 0, n_fail = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  logic [31:0] exp_d [$];
  bit exp_l [$];
  logic [7:0] exp_addr [$];
  int iss_cyc [$];
  int cyc = 0, outst = 0, n_issue = 0, mode = 0, ph = 0;
  bit done_exp = 0, prev_stall = 0, lat_on = 1;
  logic [31:0] prev_data;
  initial forever begin
    @(posedge clk); #1;
    ph++;
    out_ready = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom % 2) : (ph % 3 == 0);
  end
  always @(negedge clk) begin
    bit p;
    cyc++;
    if (rst) begin
      done_exp = 0;
      prev_stall = 0;
    end else begin
      p = out_valid && out_ready;
      check("done", done, done_exp);
      done_exp = 0;
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, prev_data);
      end
      if (!sram_csb) begin
        check("credit", (outst - int'(p)) < 2, 1);
        check("issue_expected", exp_addr.size() > 0, 1);
        if (exp_addr.size() > 0) check("sram_addr", sram_addr, exp_addr.pop_front());
        iss_cyc.push_back(cyc);
        outst++;
        n_issue++;
      end
      if (p) begin
        check("pop_expected", exp_d.size() > 0, 1);
        if (exp_d.size() > 0) begin
          bit l;
          l = exp_l.pop_front();
          check("out_data", out_data, exp_d.pop_front());
          check("out_last", out_last, l);
          if (iss_cyc.size() > 0) begin
            if (lat_on) check("latency", cyc - iss_cyc[0], 1);
            void'(iss_cyc.pop_front());
          end
          outst--;
          if (l) done_exp = 1;
        end
      end
      if (req_valid && req_ready) begin
        for (int i = 0; i < int'(req_len); i++) begin
          exp_d.push_back(mem[8'(int'(req_addr) + i)]);
          exp_l.push_back(i == int'(req_len) - 1);
          exp_addr.push_back(8'(int'(req_addr) + i));
        end
        if (req_len == 0) done_exp = 1;
      end
      prev_stall = out_valid && !out_ready;
      prev_data = out_data;
    end
  end
  task automatic burst(input int a, input int l);
    int t = 0;
    @(posedge clk); #1;
    check("req_ready", req_ready, 1);
    req_valid = 1; req_addr = 8'(a); req_len = 9'(l);
    @(posedge clk); #1;
    req_valid = 0;
    while (!done && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("done_timeout", t < 3000, 1);
    check("ready_at_done", req_ready, 1);
  endtask
  initial begin
    int base, t;
    for (int i = 0; i < 256; i++) mem[i] = i * 3;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    check("rst_req_ready", req_ready, 1);
    check("rst_csb", sram_csb, 1);
    check("rst_addr", sram_addr, 0);
    check("rst_valid", out_valid, 0);
    check("rst_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    burst(8'h10, 4);
    burst(8'hFE, 4);
    lat_on = 0; mode = 2;
    burst(8'h20, 8);
    mode = 0;
    burst(8'h00, 0);
    @(posedge clk); #1;
    check("ready_after_len0", req_ready, 1);
    lat_on = 1;
    req_valid = 1; req_addr = 8'h80; req_len = 16;
    @(posedge clk); #1;
    req_valid = 0;
    base = n_issue; t = 0;
    while (n_issue < base + 2 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("issue_wait", n_issue >= base + 2, 1);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1;
    exp_d.delete(); exp_l.delete(); exp_addr.delete(); iss_cyc.delete(); outst = 0;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_csb", sram_csb, 1);
    check("mid_rst_busy", busy, 0);
    rst = 0;
    burst(8'h40, 2);
    lat_on = 0; mode = 1;
    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      burst($urandom_range(0, 255), $urandom_range(0, 20));
    end
    mode = 0;
    burst(8'hF0, 256);
`ifdef SRAM_RD_COLLISION_CHK_EN
    wr_csb = 0; wr_addr = 8'h12;
    burst(8'h12, 1);
    wr_csb = 1;
    check("coll_set", err_collision, 1);
    burst(8'h30, 3);
    check("coll_sticky", err_collision, 1);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    check("coll_clear", err_collision, 0);
`endif
    repeat (3) @(posedge clk);
    #1;
    check("model_empty", exp_d.size(), 0);
    check("addr_q_empty", exp_addr.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
